// File: rtl/alarm_setter.sv
// Alarm-time writer: turns debounced up/sel buttons into the stored alarm hour/minute
// and the arm flag, with hold-to-autorepeat while editing a field.
module alarm_setter #(
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       alarmon,
    input  logic       up,
    input  logic       sel,
    output logic [6:0] alarmh,
    output logic [6:0] alarmm,
    output logic       isalarm,
    output logic [1:0] editing
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2
    } state_t;

    state_t        state;
    logic          up_q;
    logic          sel_q;
    logic [CW-1:0] rpt_cnt;
    logic          rpt_held;

    logic          up_rise;
    logic          sel_rise;
    logic          rpt_tick;
    logic [6:0]    alarmh_inc;
    logic [6:0]    alarmm_inc;

    assign up_rise  = up & ~up_q;
    assign sel_rise = sel & ~sel_q;
    assign editing  = state;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rpt_tick   = 1'b0;
        alarmh_inc = (alarmh == 7'd23) ? 7'd0 : alarmh + 7'd1;
        alarmm_inc = (alarmm == 7'd59) ? 7'd0 : alarmm + 7'd1;
        if (state != IDLE && up && !up_rise)
            rpt_tick = (rpt_cnt == (rpt_held ? REPEAT_LAST : HOLD_LAST));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        // Edge registers track the buttons even in reset, so a button held through reset gives no edge.
        up_q  <= up;
        sel_q <= sel;

        if (reset) begin
            state    <= IDLE;
            alarmh   <= 7'd0;
            alarmm   <= 7'd0;
            isalarm  <= 1'b0;
            rpt_cnt  <= '0;
            rpt_held <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rpt_cnt  <= '0;
                    rpt_held <= 1'b0;
                    if (alarmon) begin
                        if (sel_rise) begin
                            state   <= EDIT_H;
                            isalarm <= 1'b0;
                        end else if (up_rise) begin
                            isalarm <= ~isalarm;
                        end
                    end
                end

                EDIT_H, EDIT_M: begin
                    if (!alarmon || sel_rise) begin
                        // Any state change restarts the repeat timing from scratch.
                        rpt_cnt  <= '0;
                        rpt_held <= 1'b0;
                        if (!alarmon) begin
                            state <= IDLE;
                        end else if (state == EDIT_H) begin
                            state <= EDIT_M;
                        end else begin
                            state   <= IDLE;
                            isalarm <= 1'b1;
                        end
                    end else begin
                        if (!up || up_rise) begin
                            rpt_cnt  <= '0;
                            rpt_held <= 1'b0;
                        end else if (rpt_tick) begin
                            rpt_cnt  <= '0;
                            rpt_held <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + CW'(1);
                        end

                        if (up_rise || rpt_tick) begin
                            if (state == EDIT_H)
                                alarmh <= alarmh_inc;
                            else
                                alarmm <= alarmm_inc;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    rpt_cnt  <= '0;
                    rpt_held <= 1'b0;
                end
            endcase
        end
    end

endmodule
